// File: rtl/spdif_subframe_assembler.sv
// spdif_subframe_assembler
//
// Deserialises the decoded S/PDIF bit stream (one bit per vin strobe, LSB
// first) into 28-bit subframes: 4 aux, 20 audio, V, U, C, P. Each completed
// subframe is emitted as a 24-bit sample plus status flags one cycle after
// its 28th bit. Left/right subframes of the same frame are paired into a
// stereo output.
//
// Optional build macro:
//   PARITY_MUTE_EN - when defined, subframes failing even parity emit a zero
//                    sample, and a zero value is latched for pairing. Flags
//                    are unchanged.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   vin, din          - decoded-bit strobe and bit value
//   channel_in        - decoder channel flag (0 = left, 1 = right)
//   frame_counter_in  - decoder frame counter (0 = block start)
//   sample_out, vout  - assembled sample and its one-cycle valid pulse
//   channel_out, validity_out, user_out, cstat_out - per-sample status
//   parity_err        - with vout: subframe failed even parity
//   block_start       - with vout: left subframe of frame 0
//   frame_err         - pulse: a partial subframe was discarded on a gap
//   left_out, right_out, pair_vout, pair_err - paired stereo output

module spdif_subframe_assembler #(
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned SAMPLE_W   = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vin,
    input  logic                din,
    input  logic                channel_in,
    input  logic [7:0]          frame_counter_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                vout,
    output logic                channel_out,
    output logic                validity_out,
    output logic                user_out,
    output logic                cstat_out,
    output logic                parity_err,
    output logic                block_start,
    output logic                frame_err,
    output logic [SAMPLE_W-1:0] left_out,
    output logic [SAMPLE_W-1:0] right_out,
    output logic                pair_vout,
    output logic                pair_err
);

    localparam logic [3:0] GapMax = 4'(GAP_CYCLES);

    typedef enum logic [0:0] {
        StIdle,
        StHaveLeft
    } pair_state_e;

    // Deserialiser state
    logic [27:0]         sr_q, sr_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [3:0]          gap_cnt_q, gap_cnt_d;

    // Per-sample registered outputs
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                vout_q, vout_d;
    logic                channel_q, channel_d;
    logic                validity_q, validity_d;
    logic                user_q, user_d;
    logic                cstat_q, cstat_d;
    logic                parity_err_q, parity_err_d;
    logic                block_start_q, block_start_d;
    logic                frame_err_q, frame_err_d;

    // Pairing state and outputs
    pair_state_e         state_q, state_d;
    logic [SAMPLE_W-1:0] left_lat_q, left_lat_d;
    logic                left_perr_q, left_perr_d;
    logic [SAMPLE_W-1:0] left_out_q, left_out_d;
    logic [SAMPLE_W-1:0] right_out_q, right_out_d;
    logic                pair_vout_q, pair_vout_d;
    logic                pair_err_q, pair_err_d;

    // Subframe as it stands once the current bit is shifted in
    logic [27:0]         word;
    logic                word_perr;
    logic [SAMPLE_W-1:0] word_sample;
    logic                complete;
    logic                discard;

    assign word      = {din, sr_q[27:1]};
    assign word_perr = ^word;

    always_comb begin
        word_sample = word[SAMPLE_W-1:0];
`ifdef PARITY_MUTE_EN
        if (word_perr) begin
            word_sample = '0;
        end
`endif
    end

    // Deserialiser and gap detection
    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        complete  = 1'b0;
        discard   = 1'b0;
        if (vin) begin
            // A bit on the cycle the gap would expire takes priority.
            sr_d      = word;
            gap_cnt_d = '0;
            if (bit_cnt_q == 5'd27) begin
                bit_cnt_d = '0;
                complete  = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end else if (gap_cnt_q != GapMax) begin
            gap_cnt_d = gap_cnt_q + 4'd1;
            // Discard fires once, on the transition into a full gap.
            if (gap_cnt_d == GapMax && bit_cnt_q != '0) begin
                discard   = 1'b1;
                bit_cnt_d = '0;
            end
        end
    end

    // Per-sample outputs: values hold between pulses, qualifiers pulse
    always_comb begin
        sample_d      = sample_q;
        channel_d     = channel_q;
        validity_d    = validity_q;
        user_d        = user_q;
        cstat_d       = cstat_q;
        vout_d        = complete;
        parity_err_d  = complete & word_perr;
        block_start_d = complete & ~channel_in & (frame_counter_in == 8'd0);
        frame_err_d   = discard;
        if (complete) begin
            sample_d   = word_sample;
            channel_d  = channel_in;
            validity_d = word[24];
            user_d     = word[25];
            cstat_d    = word[26];
        end
    end

    // Left/right pairing
    always_comb begin
        state_d     = state_q;
        left_lat_d  = left_lat_q;
        left_perr_d = left_perr_q;
        left_out_d  = left_out_q;
        right_out_d = right_out_q;
        pair_vout_d = 1'b0;
        pair_err_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A right subframe with no pending left is not paired.
                if (complete && !channel_in) begin
                    left_lat_d  = word_sample;
                    left_perr_d = word_perr;
                    state_d     = StHaveLeft;
                end
            end
            StHaveLeft: begin
                if (complete) begin
                    if (channel_in) begin
                        left_out_d  = left_lat_q;
                        right_out_d = word_sample;
                        pair_vout_d = 1'b1;
                        pair_err_d  = left_perr_q | word_perr;
                        state_d     = StIdle;
                    end else begin
                        left_lat_d  = word_sample;
                        left_perr_d = word_perr;
                    end
                end else if (discard) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            sample_q      <= '0;
            vout_q        <= 1'b0;
            channel_q     <= 1'b0;
            validity_q    <= 1'b0;
            user_q        <= 1'b0;
            cstat_q       <= 1'b0;
            parity_err_q  <= 1'b0;
            block_start_q <= 1'b0;
            frame_err_q   <= 1'b0;
            state_q       <= StIdle;
            left_lat_q    <= '0;
            left_perr_q   <= 1'b0;
            left_out_q    <= '0;
            right_out_q   <= '0;
            pair_vout_q   <= 1'b0;
            pair_err_q    <= 1'b0;
        end else begin
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            sample_q      <= sample_d;
            vout_q        <= vout_d;
            channel_q     <= channel_d;
            validity_q    <= validity_d;
            user_q        <= user_d;
            cstat_q       <= cstat_d;
            parity_err_q  <= parity_err_d;
            block_start_q <= block_start_d;
            frame_err_q   <= frame_err_d;
            state_q       <= state_d;
            left_lat_q    <= left_lat_d;
            left_perr_q   <= left_perr_d;
            left_out_q    <= left_out_d;
            right_out_q   <= right_out_d;
            pair_vout_q   <= pair_vout_d;
            pair_err_q    <= pair_err_d;
        end
    end

    assign sample_out   = sample_q;
    assign vout         = vout_q;
    assign channel_out  = channel_q;
    assign validity_out = validity_q;
    assign user_out     = user_q;
    assign cstat_out    = cstat_q;
    assign parity_err   = parity_err_q;
    assign block_start  = block_start_q;
    assign frame_err    = frame_err_q;
    assign left_out     = left_out_q;
    assign right_out    = right_out_q;
    assign pair_vout    = pair_vout_q;
    assign pair_err     = pair_err_q;

endmodule

// File: tb/tb_spdif_subframe_assembler.sv
// Self-checking bench for spdif_subframe_assembler. Expected samples and
// pairs are queued as subframes are sent and checked by a monitor that runs
// on the falling clock edge.

module tb_spdif_subframe_assembler;

    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vin = 1'b0;
    logic        din = 1'b0;
    logic        channel_in = 1'b0;
    logic [7:0]  frame_counter_in = 8'd1;
    logic [23:0] sample_out;
    logic        vout, channel_out, validity_out, user_out, cstat_out;
    logic        parity_err, block_start, frame_err;
    logic [23:0] left_out, right_out;
    logic        pair_vout, pair_err;

    spdif_subframe_assembler #(
        .GAP_CYCLES(GAP),
        .SAMPLE_W  (24)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .vin             (vin),
        .din             (din),
        .channel_in      (channel_in),
        .frame_counter_in(frame_counter_in),
        .sample_out      (sample_out),
        .vout            (vout),
        .channel_out     (channel_out),
        .validity_out    (validity_out),
        .user_out        (user_out),
        .cstat_out       (cstat_out),
        .parity_err      (parity_err),
        .block_start     (block_start),
        .frame_err       (frame_err),
        .left_out        (left_out),
        .right_out       (right_out),
        .pair_vout       (pair_vout),
        .pair_err        (pair_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] s;
        logic        ch, v, u, c, pe, bs;
    } vexp_t;

    typedef struct packed {
        logic [23:0] l, r;
        logic        pe;
    } pexp_t;

    vexp_t       vq[$];
    pexp_t       pq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_vout = 0;
    int          n_pair = 0;
    int          n_ferr = 0;
    logic        pre_vout, post_vout;
    // Reference pairing model
    logic        m_pend = 1'b0;
    logic [23:0] m_left = '0;
    logic        m_lpe = 1'b0;

    task automatic monitor();
        vexp_t ev, gv;
        pexp_t ep, gp;
        forever begin
            @(negedge clk);
            if (vout === 1'b1) begin
                n_vout++;
                n_cmp++;
                if (vq.size() == 0) begin
                    n_bad++;
                    $display("FAIL vout_unexpected: got sample %h, required no vout", sample_out);
                end else begin
                    ev = vq.pop_front();
                    gv = {sample_out, channel_out, validity_out, user_out, cstat_out,
                          parity_err, block_start};
                    if (gv !== ev) begin
                        n_bad++;
                        $display("FAIL vout_fields: got s=%h ch/v/u/c/pe/bs=%b, required s=%h %b",
                                 gv.s, gv[5:0], ev.s, ev[5:0]);
                    end
                end
            end
            if (pair_vout === 1'b1) begin
                n_pair++;
                n_cmp++;
                if (pq.size() == 0) begin
                    n_bad++;
                    $display("FAIL pair_unexpected: got l=%h r=%h, required no pair",
                             left_out, right_out);
                end else begin
                    ep = pq.pop_front();
                    gp = {left_out, right_out, pair_err};
                    if (gp !== ep) begin
                        n_bad++;
                        $display("FAIL pair_fields: got l=%h r=%h e=%b, required l=%h r=%h e=%b",
                                 gp.l, gp.r, gp.pe, ep.l, ep.r, ep.pe);
                    end
                end
            end
            if (frame_err === 1'b1) n_ferr++;
        end
    endtask

    task automatic idle(input int n);
        vin = 1'b0;
        din = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        pre_vout = vout;
        vin = 1'b1;
        din = b;
        @(posedge clk);
        #1;
        post_vout = vout;
        idle(gap);
    endtask

    // Sends the low nbits of a subframe; only complete ones are expected out.
    task automatic send_sub(input logic [23:0] s, input logic v, input logic u, input logic c,
                            input logic flip, input logic ch, input logic [7:0] fc,
                            input int nbits, input int gap);
        logic [27:0] w;
        logic [23:0] es;
        w = {(^{c, u, v, s}) ^ flip, c, u, v, s};
        es = s;
`ifdef PARITY_MUTE_EN
        if (flip) es = '0;
`endif
        channel_in = ch;
        frame_counter_in = fc;
        if (nbits == 28) begin
            vq.push_back({es, ch, v, u, c, flip, (!ch && fc == 8'd0)});
            if (!ch) begin
                m_pend = 1'b1;
                m_left = es;
                m_lpe = flip;
            end else if (m_pend) begin
                pq.push_back({m_left, es, m_lpe | flip});
                m_pend = 1'b0;
            end
        end
        for (int i = 0; i < nbits; i++) send_bit(w[i], gap);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        m_pend = 1'b0;
        n_cmp++;
        if ({vout, pair_vout, frame_err, parity_err, block_start} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b, required 00000",
                     {vout, pair_vout, frame_err, parity_err, block_start});
        end
        n_cmp++;
        if (sample_out !== 24'h0 || left_out !== 24'h0 || right_out !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h %h %h, required zeros",
                     sample_out, left_out, right_out);
        end
        n_cmp++;
        if ({channel_out, validity_out, user_out, cstat_out, pair_err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {channel_out, validity_out, user_out, cstat_out, pair_err});
        end
    endtask

    task automatic test_basic();
        send_sub(24'hABCDE0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 28, 1);
        n_cmp++;
        if ({pre_vout, post_vout} !== 2'b01) begin
            n_bad++;
            $display("FAIL basic_latency: got before/after last bit %b, required 01",
                     {pre_vout, post_vout});
        end
        idle(2);
        n_cmp++;
        if (sample_out !== 24'hABCDE0 || cstat_out !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_hold: got %h c=%b, required abcde0 c=1", sample_out, cstat_out);
        end
    endtask

    task automatic test_pair();
        int p0, f0;
        p0 = n_pair;
        f0 = n_ferr;
        send_sub(24'h123456, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 28, 1);
        idle(8);
        send_sub(24'h654321, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 28, 1);
        idle(3);
        n_cmp++;
        if (n_pair - p0 !== 1 || n_ferr !== f0) begin
            n_bad++;
            $display("FAIL pair_count: got pairs %0d ferr %0d, required 1 0", n_pair - p0,
                     n_ferr - f0);
        end
        n_cmp++;
        if (left_out !== 24'h123456 || right_out !== 24'h654321) begin
            n_bad++;
            $display("FAIL pair_hold: got %h %h, required 123456 654321", left_out, right_out);
        end
    endtask

    task automatic test_parity();
        send_sub(24'h5A5A5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd9, 28, 1);
        send_sub(24'h0F0F0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd9, 28, 1);
        send_sub(24'h00FF00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd9, 28, 1);
        idle(2);
    endtask

    task automatic test_frame_err();
        int f0, v0, p0;
        f0 = n_ferr;
        v0 = n_vout;
        p0 = n_pair;
        send_sub(24'h111111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 10, 1);
        idle(6);
        n_cmp++;
        if (n_ferr - f0 !== 1 || n_vout !== v0) begin
            n_bad++;
            $display("FAIL ferr_partial: got ferr %0d vout %0d, required 1 0", n_ferr - f0,
                     n_vout - v0);
        end
        send_sub(24'h2468AC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 28, 1);
        // Left pending, then a partial subframe discards it.
        send_sub(24'h777777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 28, 1);
        send_sub(24'h888888, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 5, 1);
        idle(6);
        m_pend = 1'b0;
        send_sub(24'h999999, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 28, 1);
        idle(2);
        n_cmp++;
        if (n_ferr - f0 !== 2 || n_pair !== p0) begin
            n_bad++;
            $display("FAIL ferr_pending: got ferr %0d pairs %0d, required 2 0", n_ferr - f0,
                     n_pair - p0);
        end
    endtask

    task automatic test_vin_wins();
        int f0;
        f0 = n_ferr;
        send_sub(24'hC0FFEE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4, 28, GAP - 1);
        send_sub(24'hBEEF01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 28, GAP - 1);
        idle(2);
        n_cmp++;
        if (n_ferr !== f0) begin
            n_bad++;
            $display("FAIL vin_wins: got %0d frame_err, required 0", n_ferr - f0);
        end
    endtask

    task automatic test_block_start();
        send_sub(24'h00ABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 28, 1);
        send_sub(24'hFEDCBA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 28, 1);
        idle(2);
    endtask

    task automatic test_reset_mid();
        int f0, p0;
        send_sub(24'h3C3C3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6, 15, 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        m_pend = 1'b0;
        f0 = n_ferr;
        p0 = n_pair;
        send_sub(24'h4B4B4B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6, 28, 1);
        idle(6);
        n_cmp++;
        if (n_ferr !== f0 || n_pair !== p0) begin
            n_bad++;
            $display("FAIL reset_mid: got ferr %0d pairs %0d, required 0 0", n_ferr - f0,
                     n_pair - p0);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] s;
        for (int i = 0; i < 8; i++) begin
            s = 24'($urandom);
            send_sub(s, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'(i % 2),
                     8'($urandom_range(1, 191)), 28, 1);
        end
        idle(3);
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_pair();
        test_parity();
        test_frame_err();
        test_vin_wins();
        test_block_start();
        test_reset_mid();
        test_back_to_back();
        idle(4);
        n_cmp++;
        if (vq.size() != 0 || pq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d samples %0d pairs outstanding, required 0 0",
                     vq.size(), pq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spdif_subframe_assembler.md
Name: spdif_subframe_assembler

Overview:
Sits directly downstream of the biphase-mark decoder and consumes its decoded serial bit stream (one data bit per valid pulse) plus its channel and frame-counter side outputs. Deserialises each 28-bit subframe (4 aux, 20 audio, V, U, C, P; LSB first), checks even parity and emits a 24-bit sample with status flags. Also pairs left and right subframes of the same frame into a stereo sample pair for the audio sink.

Parameters:
GAP_CYCLES, 4, consecutive cycles with vin low that mark a subframe boundary (preamble gap); legal range 2..15
SAMPLE_W, 24, output sample width; fixed at 24, bits 0..23 of the subframe payload

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
vin  input  1  decoded-bit valid strobe from the decoder
din  input  1  decoded bit, sampled when vin=1
channel_in  input  1  decoder channel flag (0=left, 1=right)
frame_counter_in  input  8  decoder frame counter (0 = block start)
sample_out  output  24  assembled sample (aux bits in [3:0], audio MSB at [23])
vout  output  1  one-cycle pulse: sample_out and flags valid
channel_out  output  1  channel of the emitted sample
validity_out  output  1  V bit of the subframe
user_out  output  1  U bit
cstat_out  output  1  C bit
parity_err  output  1  high with vout when XOR of all 28 bits is 1
block_start  output  1  high with vout when channel_out=0 and frame_counter_in was 0 at capture
frame_err  output  1  one-cycle pulse when a partial subframe (1..27 bits) is discarded
left_out  output  24  paired left sample
right_out  output  24  paired right sample
pair_vout  output  1  one-cycle pulse: left_out/right_out valid
pair_err  output  1  high with pair_vout if either subframe had parity_err

Behaviour:
- Reset: all outputs 0; bit_cnt=0, gap_cnt=0, shift register 0, left_pending=0.
- Shift: on vin=1, sr <= {din, sr[27:1]}; bit_cnt increments; gap_cnt cleared.
- Completion: vin=1 with bit_cnt=27 -> bit_cnt<=0; next cycle vout=1 with sample_out=payload[23:0], validity=bit24, user=bit25, cstat=bit26, parity_err = XOR of payload[27:0]. Latency: 1 cycle after the 28th vin.
- channel_out and block_start captured from channel_in/frame_counter_in on the completing vin cycle.
- Gap: each cycle with vin=0 increments gap_cnt (saturating at GAP_CYCLES). On reaching GAP_CYCLES: if bit_cnt in 1..27, frame_err pulses next cycle and bit_cnt<=0; if bit_cnt=0, no pulse. Decoder emits bits every 2nd cycle, so a single idle cycle never resets.
- vin=1 on the same cycle gap_cnt would reach GAP_CYCLES: vin wins; bit accepted, no discard.
- Pairing states: IDLE (left_pending=0), HAVE_LEFT (left_pending=1).
  IDLE + left completion -> latch left sample/parity, HAVE_LEFT.
  HAVE_LEFT + right completion -> next cycle pair_vout=1, left_out/right_out updated, pair_err = OR of parities, IDLE.
  HAVE_LEFT + left completion -> overwrite latched left, stay HAVE_LEFT.
  IDLE + right completion -> right dropped for pairing (still on vout), stay IDLE.
  frame_err while HAVE_LEFT -> IDLE (latched left discarded).
- pair_vout and vout may coincide (pair pulses same cycle as the right vout).
- left_out/right_out/sample_out hold their values between pulses.
- rst mid-subframe: partial bits and pending left discarded, no frame_err pulse.

Optional Feature:
PARITY_MUTE_EN: when defined, a subframe with parity_err outputs sample_out=0 and its latched paired value is 0; flags and parity_err unchanged. When undefined, the sample passes through unmodified and only parity_err/pair_err flag the error.

Test Plan:
- Reset, then 28 bits of payload 0x0ABCDE0 ordered LSB first with V=0,U=0,C=1, P chosen for even parity, vin every 2 cycles, channel_in=0 -> one vout, sample_out=0xABCDE0, cstat_out=1, parity_err=0, 1 cycle after the last vin.
- Left 0x123456, then 8-cycle gap, then right 0x654321, frame_counter_in=5 -> pair_vout once with left_out=0x123456, right_out=0x654321, pair_err=0, block_start=0.
- Subframe with P flipped -> parity_err=1 with vout; with PARITY_MUTE_EN sample_out=0x000000, without it sample_out=payload.
- 10 bits then 6 idle cycles (GAP_CYCLES=4) -> frame_err pulse, no vout; the next full subframe is assembled correctly.
- Left subframe with frame_counter_in=0 -> block_start=1 with vout; right subframe with no prior left -> vout=1, no pair_vout.
- Assert rst after 15 bits of a left subframe, then a full right subframe -> no frame_err, right vout only, no pair_vout.
